// File: rtl/branch_resolve.sv
// branch_resolve: evaluates decode-stage branch flags against forwarded
// operands, tracks the MIPS delay slot and issues a single registered
// fetch redirect once the delay-slot instruction has been accepted.
module branch_resolve #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LINK_OFFSET = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             bgt,
  input  logic             beq,
  input  logic             blt,
  input  logic             rt_is_zero,
  input  logic             link_reg,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] pc,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             link_valid,
  output logic [WIDTH-1:0] link_value,
  output logic             branch_busy,
  output logic             delay_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_nxt;
  logic             redirect_valid_nxt;
  logic [WIDTH-1:0] redirect_pc_nxt;
  logic             link_valid_nxt;
  logic [WIDTH-1:0] link_value_nxt;
  logic             branch_busy_nxt;
  logic             delay_fault_nxt;

  logic             accept;
  logic [WIDTH-1:0] rt_eff;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             taken;

  assign in_ready = !stall;
  assign accept   = in_valid & !stall;

  // Signed compare of rs against rt (or zero) and taken decision
  always_comb begin
    rt_eff = rt_is_zero ? '0 : rt_value;
    cmp_gt = $signed(rs_value) >  $signed(rt_eff);
    cmp_eq = rs_value == rt_eff;
    cmp_lt = $signed(rs_value) <  $signed(rt_eff);
    taken  = (bgt & cmp_gt) | (beq & cmp_eq) | (blt & cmp_lt);
  end

  // Next-state and next-output logic; pulses default low, data holds
  always_comb begin
    state_nxt          = state;
    target_nxt         = target_q;
    redirect_valid_nxt = 1'b0;
    redirect_pc_nxt    = redirect_pc;
    link_valid_nxt     = 1'b0;
    link_value_nxt     = link_value;
    delay_fault_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept && is_branch) begin
          // Link is written whether or not the branch is taken
          if (link_reg) begin
            link_valid_nxt = 1'b1;
            link_value_nxt = pc + WIDTH'(LINK_OFFSET);
          end
          if (taken) begin
            target_nxt = target;
            state_nxt  = SLOT;
          end
        end
      end
      SLOT: begin
        // A branch sitting in the delay slot is flagged, never evaluated
        if (accept) begin
          state_nxt          = FIRE;
          redirect_valid_nxt = 1'b1;
          redirect_pc_nxt    = target_q;
          delay_fault_nxt    = is_branch;
        end
      end
      FIRE: begin
        // Wrong-path instruction (if any) is dropped; stall does not hold FIRE
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    branch_busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      target_q       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_valid     <= 1'b0;
      link_value     <= '0;
      branch_busy    <= 1'b0;
      delay_fault    <= 1'b0;
    end else begin
      state          <= state_nxt;
      target_q       <= target_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      link_valid     <= link_valid_nxt;
      link_value     <= link_value_nxt;
      branch_busy    <= branch_busy_nxt;
      delay_fault    <= delay_fault_nxt;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve.
module tb_branch_resolve;

  localparam int unsigned WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             is_branch;
  logic             bgt;
  logic             beq;
  logic             blt;
  logic             rt_is_zero;
  logic             link_reg;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             link_valid;
  logic [WIDTH-1:0] link_value;
  logic             branch_busy;
  logic             delay_fault;

  int total = 0;
  int bad   = 0;

  branch_resolve #(.WIDTH(WIDTH), .LINK_OFFSET(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stall          (stall),
    .is_branch      (is_branch),
    .bgt            (bgt),
    .beq            (beq),
    .blt            (blt),
    .rt_is_zero     (rt_is_zero),
    .link_reg       (link_reg),
    .rs_value       (rs_value),
    .rt_value       (rt_value),
    .target         (target),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_valid     (link_valid),
    .link_value     (link_value),
    .branch_busy    (branch_busy),
    .delay_fault    (delay_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctl = {reset, in_valid, stall, is_branch, bgt, beq, blt, rt_is_zero, link_reg}
  // exp = {redirect_valid, link_valid, branch_busy, delay_fault} after the edge
  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] tgt;
    logic [31:0] pcv;
    logic [3:0]  exp;
    logic [31:0] exp_rpc;
    logic [31:0] exp_lval;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one vector, check in_ready, clock once, check registered outputs
  task automatic apply(input vec_t v, input string tag);
    {reset, in_valid, stall, is_branch, bgt, beq, blt, rt_is_zero, link_reg} = v.ctl;
    rs_value = v.rs;
    rt_value = v.rt;
    target   = v.tgt;
    pc       = v.pcv;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!v.ctl[6]));
    @(posedge clock);
    #1;
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(v.exp[3]));
    chk({tag, ".link_valid"},     32'(link_valid),     32'(v.exp[2]));
    chk({tag, ".branch_busy"},    32'(branch_busy),    32'(v.exp[1]));
    chk({tag, ".delay_fault"},    32'(delay_fault),    32'(v.exp[0]));
    chk({tag, ".redirect_pc"},    redirect_pc,         v.exp_rpc);
    chk({tag, ".link_value"},     link_value,          v.exp_lval);
  endtask

  vec_t tbl[18];

  initial begin
    {reset, in_valid, stall, is_branch, bgt, beq, blt, rt_is_zero, link_reg} = 9'b1_0000_0000;
    rs_value = '0; rt_value = '0; target = '0; pc = '0;

    // reset
    tbl[0]  = '{9'b1_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0};
    // BEQ 5==5 taken, slot, redirect to 0x100, no link
    tbl[1]  = '{9'b0_1_0_1_0_1_0_0_0, 32'h5, 32'h5, 32'h100, 32'h40, 4'b0010, 32'h0, 32'h0};
    tbl[2]  = '{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h44, 4'b1010, 32'h100, 32'h0};
    tbl[3]  = '{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h100, 32'h0};
    // BNE 7!=7 false: not taken
    tbl[4]  = '{9'b0_1_0_1_1_0_1_0_0, 32'h7, 32'h7, 32'h900, 32'h48, 4'b0000, 32'h100, 32'h0};
    // BLTZAL rs=-1: link 0x208, redirect 0x80 after slot
    tbl[5]  = '{9'b0_1_0_1_0_0_1_1_1, 32'hFFFFFFFF, 32'h1234, 32'h80, 32'h200, 4'b0110, 32'h100, 32'h208};
    tbl[6]  = '{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h204, 4'b1010, 32'h80, 32'h208};
    tbl[7]  = '{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h80, 32'h208};
    // stalled linking BEQ in IDLE is not accepted
    tbl[8]  = '{9'b0_1_1_1_0_1_0_0_1, 32'h3, 32'h3, 32'hA00, 32'h60, 4'b0000, 32'h80, 32'h208};
    // BGT signed: 1 > -1 taken
    tbl[9]  = '{9'b0_1_0_1_1_0_0_0_0, 32'h1, 32'hFFFFFFFF, 32'h500, 32'h10, 4'b0010, 32'h80, 32'h208};
    tbl[10] = '{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h14, 4'b1010, 32'h500, 32'h208};
    tbl[11] = '{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h500, 32'h208};
    // linking BEQ taken, slot, then a linking jump in FIRE is ignored
    tbl[12] = '{9'b0_1_0_1_0_1_0_0_1, 32'h9, 32'h9, 32'h600, 32'h20, 4'b0110, 32'h500, 32'h28};
    tbl[13] = '{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h24, 4'b1010, 32'h600, 32'h28};
    tbl[14] = '{9'b0_1_0_1_1_1_1_0_1, 32'h1, 32'h2, 32'h700, 32'h30, 4'b0000, 32'h600, 32'h28};
    tbl[15] = '{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h600, 32'h28};
    // BGEZAL with rs=-1: not taken, still links
    tbl[16] = '{9'b0_1_0_1_1_1_0_1_1, 32'hFFFFFFFF, 32'h0, 32'hB00, 32'h40, 4'b0100, 32'h600, 32'h48};
    tbl[17] = '{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h600, 32'h48};

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // J with three stall cycles before the slot
    apply('{9'b0_1_0_1_1_1_1_0_0, 32'h1, 32'h2, 32'h2000, 32'h1000, 4'b0010, 32'h600, 32'h48}, "j");
    for (int i = 0; i < 3; i++)
      apply('{9'b0_1_1_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h1004, 4'b0010, 32'h600, 32'h48},
            $sformatf("j_stall%0d", i));
    apply('{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h1004, 4'b1010, 32'h2000, 32'h48}, "j_slot");
    apply('{9'b0_1_1_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h1008, 4'b0000, 32'h2000, 32'h48}, "j_after");

    // taken branch with a taken linking branch in its delay slot
    apply('{9'b0_1_0_1_0_1_0_0_0, 32'h4, 32'h4, 32'h3000, 32'h4C, 4'b0010, 32'h2000, 32'h48}, "df_br");
    apply('{9'b0_1_0_1_0_1_0_0_1, 32'h6, 32'h6, 32'h300, 32'h50, 4'b1011, 32'h3000, 32'h48}, "df_slot");
    apply('{9'b0_0_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h3000, 32'h48}, "df_idle0");
    apply('{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h54, 4'b0000, 32'h3000, 32'h48}, "df_idle1");

    // reset while in SLOT discards the pending redirect
    apply('{9'b0_1_0_1_0_1_0_0_0, 32'h8, 32'h8, 32'h4000, 32'h60, 4'b0010, 32'h3000, 32'h48}, "rst_br");
    apply('{9'b1_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h64, 4'b0000, 32'h0, 32'h0}, "rst_hit");
    apply('{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h68, 4'b0000, 32'h0, 32'h0}, "rst_after0");
    apply('{9'b0_1_0_0_0_0_0_0_0, 32'h0, 32'h0, 32'h0, 32'h6C, 4'b0000, 32'h0, 32'h0}, "rst_after1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
